nibble_loop_sequencer: RTL and testbench

NIBBLE_LOOP_SEQUENCER -- requirements
Module: nibble_loop_sequencer

---
 rtl/nibble_loop_sequencer_pkg.sv | 38 +++
 rtl/nibble_loop_sequencer_if.sv | 34 +++
 rtl/nibble_loop_sequencer.sv | 131 +++++++++++++
 tb/tb_nibble_loop_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_loop_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// nibble_loop_sequencer_pkg : shared ALU command types, sequencer FSM states
// Revision : 1.0
// =============================================================================
package nibble_loop_sequencer_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4
   } AluCmd;

   typedef struct packed {
      AluCmd      cmd;
      logic [2:0] nibbles;
      logic       w2_signed;
   } AluCtrl;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      START = 3'd2,
      RUN   = 3'd3,
      RESP  = 3'd4
   } seq_state_t;

   localparam int unsigned WATCHDOG_DEFAULT = 16;

   // Sign bit of the most significant nibble taking part in the operation.
   function automatic logic nibble_msb(input logic [31:0] w, input logic [2:0] idx);
      return w[{idx, 2'b11}];
   endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_loop_sequencer_if.sv
`default_nettype none
// =============================================================================
// nibble_loop_sequencer_if : request/response handshake bundle
// Revision : 1.0
// =============================================================================
interface nibble_loop_sequencer_if;
   import nibble_loop_sequencer_pkg::*;

   logic        req_valid;
   logic        req_ready;
   AluCmd       req_cmd;
   logic [31:0] req_w1;
   logic [31:0] req_w2;
   logic [2:0]  req_nibbles;
   logic        req_w2_signed;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic        resp_err;
   logic [4:0]  resp_cycles;

   modport master (
      output req_valid, req_cmd, req_w1, req_w2, req_nibbles, req_w2_signed, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_err, resp_cycles
   );

   modport slave (
      input  req_valid, req_cmd, req_w1, req_w2, req_nibbles, req_w2_signed, resp_ready,
      output req_ready, resp_valid, resp_result, resp_err, resp_cycles
   );

endinterface
`default_nettype wire

// File: rtl/nibble_loop_sequencer.sv
`default_nettype none
// =============================================================================
// nibble_loop_sequencer : arms, starts and supervises an external nibble loop
// Revision : 1.0
// =============================================================================
module nibble_loop_sequencer
   import nibble_loop_sequencer_pkg::*;
#(
   parameter int unsigned WATCHDOG_LIMIT = WATCHDOG_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   nibble_loop_sequencer_if.slave        bus,
   output logic                          loop_perm_to_count,
   output logic [2:0]                    loop_nibbles_number,
   output AluCmd                         loop_cmd,
   output logic                          word2_is_signed_and_negative,
   output logic [31:0]                   word1,
   output logic [31:0]                   word2,
   output logic [31:0]                   preinit_result,
   input  logic                          loop_busy,
   input  logic [31:0]                   loop_result
);

   seq_state_t  state_q, state_d;
   AluCtrl      ctrl_q, ctrl_d;
   logic [31:0] w1_q, w1_d;
   logic [31:0] w2_q, w2_d;
   logic        neg_q, neg_d;
   logic        perm_q, perm_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_result_q, resp_result_d;
   logic        resp_err_q, resp_err_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [4:0]  cnt_inc;

   always_comb begin
      state_d       = state_q;
      ctrl_d        = ctrl_q;
      w1_d          = w1_q;
      w2_d          = w2_q;
      neg_d         = neg_q;
      resp_result_d = resp_result_q;
      resp_err_d    = resp_err_q;
      cnt_d         = cnt_q;
      cnt_inc       = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               ctrl_d  = '{cmd: bus.req_cmd, nibbles: bus.req_nibbles, w2_signed: bus.req_w2_signed};
               w1_d    = bus.req_w1;
               w2_d    = bus.req_w2;
               neg_d   = bus.req_w2_signed & nibble_msb(bus.req_w2, bus.req_nibbles);
               cnt_d   = 5'd0;
               state_d = ARM;
            end
         end
         ARM:   state_d = START;
         START: begin
            cnt_d   = cnt_inc;
            state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_inc;
            // A finished loop wins over the watchdog on the same edge.
            if (!loop_busy) begin
               resp_result_d = loop_result;
               resp_err_d    = 1'b0;
               state_d       = RESP;
            end else if ({27'd0, cnt_inc} >= WATCHDOG_LIMIT) begin
               resp_result_d = loop_result;
               resp_err_d    = 1'b1;
               state_d       = RESP;
            end
         end
         RESP: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      perm_d       = (state_d == START) || (state_d == RUN);
      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ctrl_q        <= '0;
         w1_q          <= '0;
         w2_q          <= '0;
         neg_q         <= 1'b0;
         perm_q        <= 1'b0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_err_q    <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         ctrl_q        <= ctrl_d;
         w1_q          <= w1_d;
         w2_q          <= w2_d;
         neg_q         <= neg_d;
         perm_q        <= perm_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_result_q <= resp_result_d;
         resp_err_q    <= resp_err_d;
         cnt_q         <= cnt_d;
      end
   end

   assign bus.req_ready                = req_ready_q;
   assign bus.resp_valid               = resp_valid_q;
   assign bus.resp_result              = resp_result_q;
   assign bus.resp_err                 = resp_err_q;
   assign bus.resp_cycles              = cnt_q;
   assign loop_perm_to_count           = perm_q;
   assign loop_nibbles_number          = ctrl_q.nibbles;
   assign loop_cmd                     = ctrl_q.cmd;
   assign word2_is_signed_and_negative = neg_q;
   assign word1                        = w1_q;
   assign word2                        = w2_q;
   assign preinit_result               = w1_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_loop_sequencer.sv
`default_nettype none
// =============================================================================
// tb_nibble_loop_sequencer : directed vectors against a behavioural ADD nibble loop
// Revision : 1.0
// =============================================================================
module tb_nibble_loop_sequencer;
   import nibble_loop_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        loop_perm_to_count;
   logic [2:0]  loop_nibbles_number;
   AluCmd       loop_cmd;
   logic        word2_is_signed_and_negative;
   logic [31:0] word1, word2, preinit_result;
   logic        loop_busy;
   logic [31:0] loop_result;

   logic        use_stub, stub_busy;
   logic [31:0] stub_result;

   int checks = 0;
   int errors = 0;

   nibble_loop_sequencer_if bus_if ();

   nibble_loop_sequencer u_dut (
      .clk                          (clk),
      .rst_n                        (rst_n),
      .bus                          (bus_if),
      .loop_perm_to_count           (loop_perm_to_count),
      .loop_nibbles_number          (loop_nibbles_number),
      .loop_cmd                     (loop_cmd),
      .word2_is_signed_and_negative (word2_is_signed_and_negative),
      .word1                        (word1),
      .word2                        (word2),
      .preinit_result               (preinit_result),
      .loop_busy                    (loop_busy),
      .loop_result                  (loop_result)
   );

   always #5 clk = ~clk;

   // Behavioural ADD loop: one nibble of word2 per cycle, last nibble sign-extended.
   logic [2:0]  m_idx;
   logic [31:0] m_acc, m_term;
   logic        m_done;

   always_comb begin
      m_term = {28'd0, word2[{m_idx, 2'b00} +: 4]} << {m_idx, 2'b00};
      if (m_idx == loop_nibbles_number && word2_is_signed_and_negative)
         m_term = m_term - (32'h10 << {m_idx, 2'b00});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idx  <= '0;
         m_acc  <= '0;
         m_done <= 1'b0;
      end else if (!loop_perm_to_count) begin
         m_idx  <= '0;
         m_acc  <= preinit_result;
         m_done <= 1'b0;
      end else if (!m_done) begin
         m_acc <= m_acc + m_term;
         m_idx <= m_idx + 3'd1;
         if (m_idx == loop_nibbles_number) m_done <= 1'b1;
      end
   end

   assign loop_busy   = use_stub ? stub_busy   : !m_done;
   assign loop_result = use_stub ? stub_result : m_acc;

   typedef struct {
      AluCmd       cmd;
      logic [31:0] w1;
      logic [31:0] w2;
      logic [2:0]  nib;
      logic        sgn;
      logic        exp_neg;
      logic [31:0] exp_res;
      int          exp_cyc;
   } vec_t;

   vec_t vecs [7];

   int          lat;
   logic        got;
   logic [31:0] cap_res, cap_w1, cap_w2, cap_pre;
   logic        cap_err, cap_neg;
   logic [4:0]  cap_cyc;
   AluCmd       cap_cmd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic start_op(input AluCmd cmd, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [2:0] nib, input logic sgn);
      @(negedge clk);
      chk("req_ready_idle", {31'd0, bus_if.req_ready}, 32'd1);
      bus_if.req_cmd       = cmd;
      bus_if.req_w1        = w1;
      bus_if.req_w2        = w2;
      bus_if.req_nibbles   = nib;
      bus_if.req_w2_signed = sgn;
      bus_if.req_valid     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      cap_neg = word2_is_signed_and_negative;
      cap_w1  = word1;
      cap_w2  = word2;
      cap_pre = preinit_result;
      cap_cmd = loop_cmd;
      lat     = 1;
   endtask

   task automatic wait_resp();
      got = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (bus_if.resp_valid) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout actual=no resp_valid required=resp_valid within 64 cycles");
      end
      cap_res = bus_if.resp_result;
      cap_err = bus_if.resp_err;
      cap_cyc = bus_if.resp_cycles;
   endtask

   task automatic finish_resp();
      bus_if.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.resp_ready = 1'b0;
      chk("req_ready_after_resp",  {31'd0, bus_if.req_ready},  32'd1);
      chk("resp_valid_after_resp", {31'd0, bus_if.resp_valid}, 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      start_op(v.cmd, v.w1, v.w2, v.nib, v.sgn);
      wait_resp();
      chk("vec_neg",     {31'd0, cap_neg}, {31'd0, v.exp_neg});
      chk("vec_word2",   cap_w2,  v.w2);
      chk("vec_preinit", cap_pre, v.w1);
      chk("vec_result",  cap_res, v.exp_res);
      chk("vec_err",     {31'd0, cap_err}, 32'd0);
      chk("vec_cycles",  {27'd0, cap_cyc}, 32'(v.exp_cyc));
      chk("vec_latency", 32'(lat), 32'(v.exp_cyc + 2));
      finish_resp();
   endtask

   initial begin
      vecs[0] = '{ALU_ADD, 32'h00ff0004, 32'h00000004, 3'd0, 1'b0, 1'b0, 32'h00ff0008, 2};
      vecs[1] = '{ALU_ADD, 32'h0000ffff, 32'h000000ff, 3'd1, 1'b1, 1'b1, 32'h0000fffe, 3};
      vecs[2] = '{ALU_ADD, 32'h10000000, 32'h12345678, 3'd7, 1'b0, 1'b0, 32'h22345678, 9};
      vecs[3] = '{ALU_ADD, 32'h00000010, 32'h0000000f, 3'd0, 1'b1, 1'b1, 32'h0000000f, 2};
      vecs[4] = '{ALU_ADD, 32'h00000000, 32'hfffffff8, 3'd7, 1'b1, 1'b1, 32'hfffffff8, 9};
      vecs[5] = '{ALU_ADD, 32'h00000005, 32'h00000080, 3'd1, 1'b0, 1'b0, 32'h00000085, 3};
      vecs[6] = '{ALU_ADD, 32'h00001000, 32'h00000800, 3'd2, 1'b1, 1'b1, 32'h00000800, 4};

      rst_n                = 1'b0;
      use_stub             = 1'b0;
      stub_busy            = 1'b0;
      stub_result          = '0;
      bus_if.req_valid     = 1'b0;
      bus_if.req_cmd       = ALU_ADD;
      bus_if.req_w1        = '0;
      bus_if.req_w2        = '0;
      bus_if.req_nibbles   = '0;
      bus_if.req_w2_signed = 1'b0;
      bus_if.resp_ready    = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_perm",        {31'd0, loop_perm_to_count},  32'd0);
      chk("rst_resp_valid",  {31'd0, bus_if.resp_valid},   32'd0);
      chk("rst_resp_err",    {31'd0, bus_if.resp_err},     32'd0);
      chk("rst_resp_result", bus_if.resp_result,           32'd0);
      chk("rst_resp_cycles", {27'd0, bus_if.resp_cycles},  32'd0);
      chk("rst_word1",       word1,                        32'd0);
      chk("rst_word2",       word2,                        32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready",   {31'd0, bus_if.req_ready},    32'd1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Response held off for three cycles while a new request is offered.
      start_op(ALU_ADD, 32'h00ff0004, 32'h00000004, 3'd0, 1'b0);
      wait_resp();
      for (int k = 0; k < 3; k++) begin
         bus_if.req_w1    = 32'habcdef01;
         bus_if.req_w2    = 32'h11111111;
         bus_if.req_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("stall_resp_valid",  {31'd0, bus_if.resp_valid}, 32'd1);
         chk("stall_resp_result", bus_if.resp_result,         32'h00ff0008);
         chk("stall_resp_cycles", {27'd0, bus_if.resp_cycles}, 32'd2);
         chk("stall_req_ready",   {31'd0, bus_if.req_ready},  32'd0);
         chk("stall_word1",       word1,                      32'h00ff0004);
      end
      bus_if.req_valid = 1'b0;
      finish_resp();
      @(negedge clk);
      chk("stall_no_new_op_perm",  {31'd0, loop_perm_to_count}, 32'd0);
      chk("stall_no_new_op_word1", word1,                       32'h00ff0004);

      // Reset while the loop is running abandons the operation.
      use_stub  = 1'b1;
      stub_busy = 1'b1;
      start_op(ALU_ADD, 32'h12345678, 32'h00000001, 3'd0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("run_perm_high", {31'd0, loop_perm_to_count}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_run_perm",       {31'd0, loop_perm_to_count}, 32'd0);
      chk("rst_in_run_resp_valid", {31'd0, bus_if.resp_valid},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus_if.resp_valid) got = 1'b1;
      end
      chk("rst_in_run_no_resp", {31'd0, got}, 32'd0);
      use_stub  = 1'b0;
      stub_busy = 1'b0;
      run_vec(vecs[1]);

      // Loop that never finishes trips the watchdog.
      use_stub    = 1'b1;
      stub_busy   = 1'b1;
      stub_result = 32'hdeadbeef;
      start_op(ALU_ADD, 32'h00000001, 32'h00000002, 3'd3, 1'b0);
      wait_resp();
      chk("wd_err",     {31'd0, cap_err}, 32'd1);
      chk("wd_cycles",  {27'd0, cap_cyc}, 32'd16);
      chk("wd_result",  cap_res,          32'hdeadbeef);
      chk("wd_latency", 32'(lat),         32'd18);
      finish_resp();

      // Loop idle from the first RUN cycle: minimum latency.
      stub_busy   = 1'b0;
      stub_result = 32'h13579bdf;
      start_op(ALU_ADD, 32'h00000003, 32'h00000004, 3'd5, 1'b1);
      wait_resp();
      chk("fast_err",     {31'd0, cap_err}, 32'd0);
      chk("fast_cycles",  {27'd0, cap_cyc}, 32'd2);
      chk("fast_result",  cap_res,          32'h13579bdf);
      chk("fast_latency", 32'(lat),         32'd4);
      chk("fast_cmd",     {29'd0, cap_cmd}, {29'd0, ALU_ADD});
      finish_resp();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=still running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
